// File: rtl/vga_pixel_shifter.sv
// vga_pixel_shifter
//   Text-mode pixel serializer. Each 8-pixel character cell is fetched in two
//   steps: the character code and its attribute are latched at hx==3, which
//   addresses the font ROM. The font row is then loaded into an 8-bit shift
//   register at hx==7 and shifted out MSB first, one pixel per clock. The
//   pixel colour and the syncs are registered, so both carry one cycle of
//   latency.
//
//   Optional feature, selected by the macro VGA_BLINK_EN:
//     attribute bit 7 becomes a blink flag. The background narrows to 3 bits.
//     Foreground pixels of blinking cells show the background colour while
//     bit 4 of a vsync-counted frame counter is set.
//
// Ports
//   clk, rst              pixel clock; asynchronous active-high reset
//   hx[2:0]               low bits of the horizontal pixel counter
//   vy[3:0]               glyph row (line counter low bits)
//   n_pixel_ena           active-low visible window
//   text_d, color_d       character code / attribute {bg[7:4], fg[3:0]}
//   hsync_in, vsync_in    active-low syncs from the timing generator
//   font_a[11:0]          font ROM address {char, vy} (combinational)
//   font_d[7:0]           font ROM row; bit 7 is the leftmost pixel
//   pixel[3:0]            registered colour index
//   hsync_out, vsync_out  syncs delayed by one clock, aligned with pixel
module vga_pixel_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  hx,
    input  logic [3:0]  vy,
    input  logic        n_pixel_ena,
    input  logic [7:0]  text_d,
    input  logic [7:0]  color_d,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [11:0] font_a,
    input  logic [7:0]  font_d,
    output logic [3:0]  pixel,
    output logic        hsync_out,
    output logic        vsync_out
);

    // char_q / attr_latch_q: the cell currently being fetched.
    // shreg_q / attr_disp_q: the cell currently being displayed.
    logic [7:0] char_q,      char_d;
    logic [7:0] attr_latch_q, attr_latch_d;
    logic [7:0] attr_disp_q, attr_disp_d;
    logic [7:0] shreg_q,     shreg_d;
    logic [3:0] pixel_q,     pixel_d;
    logic       hsync_q,     hsync_d;
    logic       vsync_q,     vsync_d;
    logic [3:0] fg, bg, colour;

`ifdef VGA_BLINK_EN
    logic [4:0] frame_cnt_q, frame_cnt_d;
`endif

    assign font_a    = {char_q, vy};
    assign pixel     = pixel_q;
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;

    always_comb begin
        char_d       = char_q;
        attr_latch_d = attr_latch_q;
        attr_disp_d  = attr_disp_q;
        shreg_d      = {shreg_q[6:0], 1'b0};

        if (hx == 3'd3) begin
            char_d       = text_d;
            attr_latch_d = color_d;
        end
        // The load wins over the shift, so the new row starts intact at bit 7.
        if (hx == 3'd7) begin
            shreg_d     = font_d;
            attr_disp_d = attr_latch_q;
        end

`ifdef VGA_BLINK_EN
        bg = {1'b0, attr_disp_q[6:4]};
        fg = (attr_disp_q[7] && frame_cnt_q[4]) ? bg : attr_disp_q[3:0];
        // Count vsync falling edges; vsync_q holds the previous vsync_in.
        frame_cnt_d = frame_cnt_q;
        if (!vsync_in && vsync_q)
            frame_cnt_d = frame_cnt_q + 5'd1;
`else
        bg = attr_disp_q[7:4];
        fg = attr_disp_q[3:0];
`endif

        colour  = shreg_q[7] ? fg : bg;
        pixel_d = n_pixel_ena ? 4'd0 : colour;
        hsync_d = hsync_in;
        vsync_d = vsync_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_q       <= '0;
            attr_latch_q <= '0;
            attr_disp_q  <= '0;
            shreg_q      <= '0;
            pixel_q      <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
        end else begin
            char_q       <= char_d;
            attr_latch_q <= attr_latch_d;
            attr_disp_q  <= attr_disp_d;
            shreg_q      <= shreg_d;
            pixel_q      <= pixel_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
        end
    end

`ifdef VGA_BLINK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_cnt_q <= '0;
        else     frame_cnt_q <= frame_cnt_d;
    end
`endif

endmodule
